// File: rtl/route_cntrl.sv
// route_cntrl: waypoint route sequencer.
// Commands (STOP/GO/APPEND/RESUME) manage a circular queue of 6-bit waypoint
// IDs. While in transit, a barcode ID that matches the head waypoint pops it;
// the vehicle then dwells for DWELL cycles, or goes idle if that was the last
// waypoint. A buzzer toggles every BUZZ_HALF cycles while blocked in transit.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd[7:0], cmd_rdy     command ([7:6] opcode, [5:0] dest) and its valid
//   clr_cmd_rdy           combinational consume of cmd
//   ID[7:0], ID_vld       barcode ID and its valid
//   clr_ID_vld            combinational consume of ID
//   OK2Move               path clear
//   go                    motion enable (TRANSIT and OK2Move)
//   in_transit            registered, route active
//   buzz, buzz_n          complementary obstacle buzzer
//   q_cnt, q_full         queue occupancy
//   err                   one-cycle pulse on a dropped append
module route_cntrl #(
    parameter int DEPTH     = 4,
    parameter int DWELL     = 1000,
    parameter int BUZZ_HALF = 12500
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 cmd,
    input  logic                       cmd_rdy,
    output logic                       clr_cmd_rdy,
    input  logic [7:0]                 ID,
    input  logic                       ID_vld,
    output logic                       clr_ID_vld,
    input  logic                       OK2Move,
    output logic                       go,
    output logic                       in_transit,
    output logic                       buzz,
    output logic                       buzz_n,
    output logic [$clog2(DEPTH+1)-1:0] q_cnt,
    output logic                       q_full,
    output logic                       err
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int DCW = $clog2(DWELL + 1);
    localparam int BCW = $clog2(BUZZ_HALF + 1);

    localparam logic [PW-1:0]  PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  CNT_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [BCW-1:0] BUZZ_LAST  = BCW'(BUZZ_HALF - 1);

    localparam logic [1:0] OP_STOP   = 2'b00;
    localparam logic [1:0] OP_GO     = 2'b01;
    localparam logic [1:0] OP_APPEND = 2'b10;
    localparam logic [1:0] OP_RESUME = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRANSIT = 2'd1,
        S_DWELL   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     mem_q [DEPTH];
    logic [5:0]     mem_d [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DCW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [BCW-1:0] buzz_cnt_q, buzz_cnt_d;
    logic           buzz_q, buzz_d;
    logic           err_q, err_d;
    logic           in_transit_q, in_transit_d;
    logic           id_match;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        head_d       = head_q;
        tail_d       = tail_q;
        cnt_d        = cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        buzz_cnt_d   = buzz_cnt_q;
        buzz_d       = buzz_q;
        err_d        = 1'b0;

        // A pending command blocks ID consumption so the ID is seen later.
        clr_cmd_rdy = cmd_rdy;
        clr_ID_vld  = ID_vld && !cmd_rdy;
        id_match    = (ID[7:6] == 2'b00) && (ID[5:0] == mem_q[head_q]);

        // Dwell keeps running under APPEND/RESUME; GO/STOP override below.
        if (state_q == S_DWELL) begin
            if (dwell_cnt_q == DWELL_LAST) begin
                state_d     = S_TRANSIT;
                dwell_cnt_d = '0;
            end else begin
                dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
        end

        if (cmd_rdy) begin
            case (cmd[7:6])
                OP_STOP: begin
                    head_d  = '0;
                    tail_d  = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
                OP_GO: begin
                    mem_d[0] = cmd[5:0];
                    head_d   = '0;
                    tail_d   = ptr_inc('0);
                    cnt_d    = CNT_ONE;
                    state_d  = S_TRANSIT;
                end
                OP_APPEND: begin
                    if (cnt_q == CNT_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        mem_d[tail_q] = cmd[5:0];
                        tail_d        = ptr_inc(tail_q);
                        cnt_d         = cnt_q + 1'b1;
                    end
                end
                OP_RESUME: begin
                    if (state_q == S_IDLE && cnt_q != '0)
                        state_d = S_TRANSIT;
                end
                default: ;
            endcase
        end else if (ID_vld && state_q == S_TRANSIT && id_match) begin
            head_d      = ptr_inc(head_q);
            cnt_d       = cnt_q - 1'b1;
            dwell_cnt_d = '0;
            state_d     = (cnt_q == CNT_ONE) ? S_IDLE : S_DWELL;
        end

        if (state_d != S_DWELL)
            dwell_cnt_d = '0;

        in_transit_d = (state_d != S_IDLE);

        if (state_q == S_TRANSIT && !OK2Move) begin
            if (buzz_cnt_q == BUZZ_LAST) begin
                buzz_cnt_d = '0;
                buzz_d     = !buzz_q;
            end else begin
                buzz_cnt_d = buzz_cnt_q + 1'b1;
            end
        end else begin
            buzz_cnt_d = '0;
            buzz_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mem_q        <= '{default: '0};
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
            dwell_cnt_q  <= '0;
            buzz_cnt_q   <= '0;
            buzz_q       <= 1'b0;
            err_q        <= 1'b0;
            in_transit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            cnt_q        <= cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            buzz_cnt_q   <= buzz_cnt_d;
            buzz_q       <= buzz_d;
            err_q        <= err_d;
            in_transit_q <= in_transit_d;
        end
    end

    assign go         = (state_q == S_TRANSIT) && OK2Move;
    assign in_transit = in_transit_q;
    assign buzz       = buzz_q;
    assign buzz_n     = ~buzz_q;
    assign q_cnt      = cnt_q;
    assign q_full     = (cnt_q == CNT_FULL);
    assign err        = err_q;

endmodule

// File: tb/tb_route_cntrl.sv
module tb_route_cntrl;

    localparam int DEPTH     = 4;
    localparam int DWELL     = 8;
    localparam int BUZZ_HALF = 4;

    localparam int M_IDLE    = 0;
    localparam int M_TRANSIT = 1;
    localparam int M_DWELL   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] ID;
    logic       ID_vld;
    logic       clr_ID_vld;
    logic       OK2Move;
    logic       go;
    logic       in_transit;
    logic       buzz;
    logic       buzz_n;
    logic [2:0] q_cnt;
    logic       q_full;
    logic       err;

    always #5 clk = ~clk;

    route_cntrl #(.DEPTH(DEPTH), .DWELL(DWELL), .BUZZ_HALF(BUZZ_HALF)) dut (
        .clk(clk), .rst(rst),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld),
        .OK2Move(OK2Move), .go(go), .in_transit(in_transit),
        .buzz(buzz), .buzz_n(buzz_n),
        .q_cnt(q_cnt), .q_full(q_full), .err(err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: route mode, waypoint list, remaining dwell cycles,
    // buzzer phase within its half period.
    int         m_mode;
    logic [5:0] m_q[$];
    int         m_left;
    int         m_bph;
    bit         m_buzz;
    bit         m_err;

    logic seen_clr_cmd, seen_clr_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_q.delete();
        m_left = 0;
        m_bph  = 0;
        m_buzz = 0;
        m_err  = 0;
    endtask

    task automatic model_update();
        int old;
        if (rst) begin
            model_reset();
            return;
        end
        old = m_mode;
        if (old == M_TRANSIT && !OK2Move) begin
            m_bph++;
            if (m_bph == BUZZ_HALF) begin
                m_bph  = 0;
                m_buzz = !m_buzz;
            end
        end else begin
            m_bph  = 0;
            m_buzz = 0;
        end
        m_err = 0;
        if (cmd_rdy) begin
            case (cmd[7:6])
                2'b00: begin m_q.delete(); m_mode = M_IDLE; end
                2'b01: begin m_q.delete(); m_q.push_back(cmd[5:0]); m_mode = M_TRANSIT; end
                2'b10: begin
                    if (m_q.size() < DEPTH) m_q.push_back(cmd[5:0]);
                    else m_err = 1;
                end
                default: if (old == M_IDLE && m_q.size() > 0) m_mode = M_TRANSIT;
            endcase
        end else if (ID_vld && old == M_TRANSIT && m_q.size() > 0 &&
                     ID[7:6] == 2'b00 && ID[5:0] == m_q[0]) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_mode = M_IDLE;
            else begin
                m_mode = M_DWELL;
                m_left = DWELL;
            end
        end
        if (old == M_DWELL && m_mode == M_DWELL) begin
            m_left--;
            if (m_left == 0) m_mode = M_TRANSIT;
        end
    endtask

    task automatic compare_outputs();
        chk("clr_cmd_rdy", clr_cmd_rdy, cmd_rdy);
        chk("clr_ID_vld", clr_ID_vld, ID_vld && !cmd_rdy);
        chk("go", go, (m_mode == M_TRANSIT) && OK2Move);
        chk("in_transit", in_transit, m_mode != M_IDLE);
        chk("q_cnt", q_cnt, m_q.size());
        chk("q_full", q_full, m_q.size() == DEPTH);
        chk("err", err, m_err);
        chk("buzz", buzz, m_buzz);
        chk("buzz_n", buzz_n, !m_buzz);
    endtask

    task automatic step(input bit r, input bit c_rdy, input logic [7:0] c,
                        input bit i_vld, input logic [7:0] i, input bit ok);
        @(negedge clk);
        rst = r; cmd_rdy = c_rdy; cmd = c; ID_vld = i_vld; ID = i; OK2Move = ok;
        #1;
        compare_outputs();
        seen_clr_cmd = clr_cmd_rdy;
        seen_clr_id  = clr_ID_vld;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [7:0] c);
        step(0, 1, c, 0, 8'h00, 1);
    endtask

    task automatic do_id(input logic [7:0] i);
        step(0, 0, 8'h00, 1, i, 1);
    endtask

    task automatic idle(input bit ok);
        step(0, 0, 8'h00, 0, 8'h00, ok);
    endtask

    initial begin
        int cnt;
        int toggles;
        logic prev;

        rst = 1; cmd = 0; cmd_rdy = 0; ID = 0; ID_vld = 0; OK2Move = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset q_cnt", q_cnt, 0);
        chk("reset q_full", q_full, 0);
        chk("reset in_transit", in_transit, 0);
        chk("reset buzz_n", buzz_n, 1);
        chk("reset err", err, 0);

        // Single waypoint: GO 0x45 then its ID.
        do_cmd(8'h45);
        chk("go45 clr_cmd_rdy", seen_clr_cmd, 1);
        chk("go45 in_transit", in_transit, 1);
        chk("go45 go", go, 1);
        chk("go45 q_cnt", q_cnt, 1);
        do_id(8'h05);
        chk("id05 clr_ID_vld", seen_clr_id, 1);
        chk("id05 in_transit", in_transit, 0);
        chk("id05 q_cnt", q_cnt, 0);

        // Three waypoints with dwell between them.
        do_cmd(8'h41);
        chk("route q_cnt1", q_cnt, 1);
        do_cmd(8'h82);
        chk("route q_cnt2", q_cnt, 2);
        do_cmd(8'h83);
        chk("route q_cnt3", q_cnt, 3);
        for (int w = 1; w <= 2; w++) begin
            do_id(8'(w));
            cnt = 0;
            for (int g = 0; g < 40 && go === 1'b0; g++) begin
                cnt++;
                idle(1);
            end
            chk("dwell go-low cycles", cnt, 8);
        end
        do_id(8'h03);
        chk("route end in_transit", in_transit, 0);
        chk("route end q_cnt", q_cnt, 0);

        // Queue full and dropped append.
        do_cmd(8'h41);
        do_cmd(8'h82);
        do_cmd(8'h83);
        do_cmd(8'h84);
        chk("full q_cnt", q_cnt, 4);
        chk("full q_full", q_full, 1);
        chk("full err before drop", err, 0);
        do_cmd(8'h85);
        chk("drop err", err, 1);
        chk("drop q_cnt", q_cnt, 4);
        idle(1);
        chk("drop err cleared", err, 0);

        // Blocked in transit: buzzer.
        toggles = 0;
        prev = buzz;
        for (int k = 0; k < 20; k++) begin
            idle(0);
            if (k == 2) chk("buzz before toggle", buzz, 0);
            if (k == 3) chk("buzz first toggle", buzz, 1);
            if (buzz !== prev) toggles++;
            prev = buzz;
        end
        chk("buzz toggles in 20", toggles, 5);
        idle(1);
        chk("buzz cleared", buzz, 0);
        chk("buzz_n cleared", buzz_n, 1);

        // STOP with a matching ID in the same cycle.
        step(0, 1, 8'h00, 1, 8'h01, 1);
        chk("stop+id clr_ID_vld", seen_clr_id, 0);
        chk("stop+id clr_cmd_rdy", seen_clr_cmd, 1);
        chk("stop+id q_cnt", q_cnt, 0);
        chk("stop+id in_transit", in_transit, 0);
        do_id(8'h01);
        chk("late id clr_ID_vld", seen_clr_id, 1);
        chk("late id q_cnt", q_cnt, 0);
        chk("late id in_transit", in_transit, 0);

        // Reset in the middle of a dwell.
        do_cmd(8'h41);
        do_cmd(8'h82);
        do_cmd(8'h83);
        do_id(8'h01);
        chk("dwell q_cnt", q_cnt, 2);
        chk("dwell in_transit", in_transit, 1);
        idle(1);
        idle(1);
        step(1, 1, 8'h42, 1, 8'h02, 1);
        chk("rst in_transit", in_transit, 0);
        chk("rst q_cnt", q_cnt, 0);
        chk("rst buzz_n", buzz_n, 1);
        do_cmd(8'hC0);
        chk("resume after rst in_transit", in_transit, 0);
        chk("resume after rst q_cnt", q_cnt, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bit         r, cr, iv, ok;
            logic [1:0] op;
            logic [7:0] c, i;
            int         sel;
            r   = ($urandom_range(0, 199) == 0);
            cr  = ($urandom_range(0, 9) < 3);
            sel = $urandom_range(0, 9);
            op  = (sel < 2) ? 2'b00 : (sel < 4) ? 2'b01 : (sel < 8) ? 2'b10 : 2'b11;
            c   = {op, 6'($urandom_range(0, 3))};
            iv  = ($urandom_range(0, 9) < 4);
            i   = {(($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom_range(1, 3))),
                   6'($urandom_range(0, 3))};
            if ((n / 64) % 3 == 2) ok = ($urandom_range(0, 19) == 0);
            else                   ok = ($urandom_range(0, 9) < 9);
            step(r, cr, c, iv, i, ok);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/route_cntrl.md
ROUTE_CNTRL -- requirements
Module: route_cntrl

Interface
REQ-001 Parameters SHALL be: DEPTH (default 4, >=2), waypoint queue entries; DWELL (default 1000, >=1), stop cycles at an intermediate waypoint; BUZZ_HALF (default 12500, >=2), buzzer half-period in clk cycles.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd  in  8  command: [7:6] opcode, [5:0] destination ID.
- cmd_rdy  in  1  cmd valid.
- clr_cmd_rdy  out  1  combinational; consumes cmd.
- ID  in  8  barcode ID.
- ID_vld  in  1  ID valid.
- clr_ID_vld  out  1  combinational; consumes ID.
- OK2Move  in  1  path clear.
- go  out  1  motion enable.
- in_transit  out  1  registered; route active.
- buzz, buzz_n  out  1  obstacle buzzer, complementary.
- q_cnt  out  $clog2(DEPTH+1)  queued waypoints.
- q_full  out  1  q_cnt==DEPTH.
- err  out  1  one-cycle pulse on a dropped append.

Function
REQ-003 Opcodes SHALL be: 00 STOP, 01 GO, 10 APPEND, 11 RESUME.
REQ-004 Every cycle with cmd_rdy=1 SHALL assert clr_cmd_rdy for exactly that cycle, for every opcode, including ignored commands.
REQ-005 The FSM SHALL have states IDLE, TRANSIT and DWELL; in_transit SHALL be 1 in the cycle after entering TRANSIT or DWELL, and 0 in IDLE.
REQ-006 The waypoint queue SHALL be a circular FIFO of DEPTH 6-bit entries; head and tail pointers wrap modulo DEPTH.
REQ-007 GO, in any state, SHALL flush the queue, write cmd[5:0] as the sole entry (q_cnt=1) and move to TRANSIT.
REQ-008 STOP, in any state, SHALL flush the queue (q_cnt=0) and move to IDLE.
REQ-009 APPEND, in any state, SHALL push cmd[5:0] at the tail if q_full=0.
- The state SHALL be unchanged.
- If q_full=1, the entry SHALL be dropped, the queue left unchanged, and err pulsed for 1 cycle.
REQ-010 RESUME in IDLE with q_cnt>0 SHALL move to TRANSIT; RESUME in any other case SHALL be ignored.
REQ-011 A match SHALL be ID[7:6]==2'b00 and ID[5:0]==head entry.
REQ-012 In TRANSIT, each ID_vld cycle SHALL assert clr_ID_vld.
- On a non-match, nothing else changes.
- On a match, the head SHALL be popped.
- If q_cnt becomes 0, the next state SHALL be IDLE; otherwise it SHALL be DWELL.
REQ-013 In IDLE and DWELL, ID_vld SHALL be consumed (clr_ID_vld=1) and otherwise ignored.
REQ-014 If cmd_rdy and ID_vld are both high in the same cycle, only the command SHALL be processed.
- clr_ID_vld SHALL stay 0, so the ID is handled in a later cycle.
- A push and a pop SHALL never occur in the same cycle.
REQ-015 DWELL SHALL hold for exactly DWELL cycles using a counter cleared on entry, then move to TRANSIT; GO or STOP SHALL abort DWELL immediately.
REQ-016 go SHALL equal (state==TRANSIT) && OK2Move, combinationally.
REQ-017 The buzzer SHALL be enabled while state==TRANSIT && !OK2Move.
- While enabled, a counter SHALL count 0..BUZZ_HALF-1; at BUZZ_HALF-1 it SHALL wrap to 0 and toggle buzz.
- While disabled, the counter SHALL clear to 0 and buzz SHALL be 0 on the next edge.
REQ-018 buzz_n SHALL always equal ~buzz.

Reset
REQ-019 With rst=1 at a clock edge, the following SHALL hold after that edge:
- state=IDLE;
- queue empty, q_cnt=0, q_full=0;
- dwell and buzzer counters = 0;
- in_transit=0, buzz=0, buzz_n=1, err=0.
REQ-020 rst SHALL take priority over every other input in every state, including mid-DWELL and mid-buzz; no command or ID presented in the reset cycle is retained.

Verification (DEPTH=4, DWELL=8, BUZZ_HALF=4)
REQ-021 GO 0x45, then ID=0x05 with OK2Move=1 -> the following SHALL be observed:
- clr_cmd_rdy for 1 cycle;
- in_transit=1 and go=1 from the next cycle;
- on the ID, clr_ID_vld, then IDLE with in_transit=0 and q_cnt=0.
REQ-022 GO 0x41, APPEND 0x82, APPEND 0x83, then IDs 0x01, 0x02, 0x03 -> the following SHALL be observed:
- q_cnt sequence 1, 2, 3;
- go=0 for exactly 8 cycles after 0x01 and after 0x02;
- IDLE after 0x03.
REQ-023 GO plus 4 APPENDs -> q_cnt=4 and q_full=1 after the third APPEND; the 4th APPEND pulses err and leaves q_cnt=4.
REQ-024 TRANSIT with OK2Move=0 for 20 cycles -> go=0; buzz toggles every 4 cycles; buzz_n=~buzz; OK2Move=1 returns buzz to 0.
REQ-025 Same-cycle STOP and matching ID -> queue flushed, IDLE, clr_ID_vld=0 that cycle; the ID is consumed the next cycle with no effect.
REQ-026 rst=1 during DWELL with q_cnt=2 -> after the edge, IDLE, q_cnt=0, in_transit=0; a following RESUME is ignored.
